// File: rtl/idma_txrx_tx_serializer.sv
// Byte-wide TX drain for the iDMA TXRX write task: buffers one masked data word,
// emits its enabled bytes lowest index first and counts down the programmed length.
module idma_txrx_tx_serializer #(
    parameter int unsigned StrbWidth = 16,
    parameter int unsigned LenWidth  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    input  logic [LenWidth-1:0]    cfg_len_i,
    output logic                   cfg_ready_o,
    input  logic                   abort_i,
    output logic                   word_req_o,
    output logic                   word_ready_o,
    input  logic                   word_valid_i,
    input  logic [8*StrbWidth-1:0] word_data_i,
    input  logic [StrbWidth-1:0]   word_strb_i,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic [LenWidth-1:0]    bytes_left_o,
    output logic                   done_o,
    output logic                   drop_o
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StShift
    } state_e;

    state_e                 state_q, state_d;
    logic [8*StrbWidth-1:0] hold_data_q, hold_data_d;
    logic [StrbWidth-1:0]   hold_strb_q, hold_strb_d;
    logic [LenWidth-1:0]    cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;

    logic [StrbWidth-1:0]   low_bit;
    logic [StrbWidth-1:0]   strb_rest;
    logic [7:0]             low_byte;
    logic [LenWidth-1:0]    cnt_dec;

    // Lowest enabled byte wins; an empty strobe yields zero so tx_data_o is quiet when idle.
    always_comb begin
        low_byte = 8'h00;
        for (int i = StrbWidth - 1; i >= 0; i--) begin
            if (hold_strb_q[i]) begin
                low_byte = hold_data_q[8*i +: 8];
            end
        end
    end

    assign low_bit   = hold_strb_q & (~hold_strb_q + StrbWidth'(1));
    assign strb_rest = hold_strb_q & ~low_bit;
    assign cnt_dec   = cnt_q - LenWidth'(1);

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_strb_d = hold_strb_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        drop_d      = 1'b0;

        if (abort_i) begin
            state_d     = StIdle;
            cnt_d       = '0;
            hold_strb_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid_i) begin
                        if (cfg_len_i != '0) begin
                            cnt_d   = cfg_len_i;
                            state_d = StArmed;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StArmed: begin
                    if (word_valid_i) begin
                        hold_data_d = word_data_i;
                        hold_strb_d = word_strb_i;
                        state_d     = StShift;
                    end
                end
                StShift: begin
                    if (hold_strb_q == '0) begin
                        // Fully masked word: nothing to send, ask for the next one.
                        state_d = StArmed;
                    end else if (tx_ready_i) begin
                        cnt_d       = cnt_dec;
                        hold_strb_d = strb_rest;
                        if (cnt_dec == '0) begin
                            done_d      = 1'b1;
                            drop_d      = (strb_rest != '0);
                            hold_strb_d = '0;
                            state_d     = StIdle;
                        end else if (strb_rest == '0) begin
                            state_d = StArmed;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            hold_data_q <= '0;
            hold_strb_q <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_strb_q <= hold_strb_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    // Handshake outputs depend on state only, never on word_valid_i.
    assign cfg_ready_o  = (state_q == StIdle);
    assign word_req_o   = (state_q == StArmed);
    assign word_ready_o = (state_q == StArmed);
    assign tx_valid_o   = (state_q == StShift) && (hold_strb_q != '0);
    assign tx_data_o    = low_byte;
    assign bytes_left_o = cnt_q;
    assign done_o       = done_q;
    assign drop_o       = drop_q;

endmodule

// File: tb/tb_idma_txrx_tx_serializer.sv
// Randomized self-checking bench for idma_txrx_tx_serializer; expectations come from
// a byte-compaction model over the queued words.
module tb_idma_txrx_tx_serializer;

    localparam int unsigned StrbWidth = 16;
    localparam int unsigned LenWidth  = 32;
    localparam int          MaxCycles = 2000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_valid;
    logic [LenWidth-1:0]    cfg_len;
    logic                   cfg_ready;
    logic                   abort;
    logic                   word_req;
    logic                   word_ready;
    logic                   word_valid;
    logic [8*StrbWidth-1:0] word_data;
    logic [StrbWidth-1:0]   word_strb;
    logic                   tx_valid;
    logic [7:0]             tx_data;
    logic                   tx_ready;
    logic [LenWidth-1:0]    bytes_left;
    logic                   done;
    logic                   drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idma_txrx_tx_serializer #(
        .StrbWidth(StrbWidth),
        .LenWidth (LenWidth)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_len_i   (cfg_len),
        .cfg_ready_o (cfg_ready),
        .abort_i     (abort),
        .word_req_o  (word_req),
        .word_ready_o(word_ready),
        .word_valid_i(word_valid),
        .word_data_i (word_data),
        .word_strb_i (word_strb),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .bytes_left_o(bytes_left),
        .done_o      (done),
        .drop_o      (drop)
    );

    // Words still to offer to the DUT, and an untouched copy for the model.
    logic [8*StrbWidth-1:0] wq_data[$];
    logic [StrbWidth-1:0]   wq_strb[$];
    logic [8*StrbWidth-1:0] m_data[$];
    logic [StrbWidth-1:0]   m_strb[$];

    // Model results.
    logic [7:0] exp_bytes[$];
    int         exp_acc[$];
    int         exp_done;
    logic       exp_drop;

    // Per-cycle trace of one transfer; entry i is cycle i+1 after the config accept.
    logic [7:0]          got[$];
    logic [LenWidth-1:0] tr_bl[$];
    int                  tr_cnt[$];
    logic                tr_v[$];
    logic [7:0]          tr_d[$];
    logic                tr_r[$];
    logic                tr_acc[$];
    int                  done_cyc;
    logic                timed_out;
    logic                saw_drop;
    logic                done_req;
    logic [LenWidth-1:0] done_bl;
    logic                post_done;
    logic                post_drop;

    task automatic clear_words();
        wq_data.delete();
        wq_strb.delete();
        m_data.delete();
        m_strb.delete();
    endtask

    task automatic add_word(input logic [8*StrbWidth-1:0] d, input logic [StrbWidth-1:0] s);
        wq_data.push_back(d);
        wq_strb.push_back(s);
        m_data.push_back(d);
        m_strb.push_back(s);
    endtask

    // Enabled bytes in index order, truncated to len. Cycle costs assume full rate:
    // a word with k bytes takes k+1 cycles, a fully masked word takes 2.
    task automatic model(input int len);
        int remaining;
        int cyc;
        int k;
        exp_bytes.delete();
        exp_acc.delete();
        exp_drop  = 1'b0;
        remaining = len;
        cyc       = 1;
        for (int w = 0; w < m_strb.size(); w++) begin
            if (remaining == 0) break;
            exp_acc.push_back(cyc);
            k = 0;
            for (int b = 0; b < StrbWidth; b++) begin
                if (m_strb[w][b]) begin
                    if (remaining > 0) begin
                        exp_bytes.push_back(m_data[w][8*b +: 8]);
                        remaining--;
                        k++;
                    end else begin
                        exp_drop = 1'b1;
                    end
                end
            end
            cyc += ((k == 0) ? 1 : k) + 1;
        end
        exp_done = cyc;
    endtask

    // Programs len, feeds queued words and records the outputs until done_o (bounded).
    task automatic run_xfer(input int len, input int unsigned ready_pct,
                            input int unsigned valid_pct);
        got.delete();
        tr_bl.delete();
        tr_cnt.delete();
        tr_v.delete();
        tr_d.delete();
        tr_r.delete();
        tr_acc.delete();
        done_cyc  = -1;
        timed_out = 1'b1;
        saw_drop  = 1'b0;
        done_req  = 1'b0;
        done_bl   = '0;
        cfg_valid = 1'b1;
        cfg_len   = LenWidth'(len);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_len   = '0;
        for (int cyc = 1; cyc <= MaxCycles; cyc++) begin
            if (done) begin
                done_cyc  = cyc;
                timed_out = 1'b0;
                saw_drop  = drop;
                done_req  = word_req;
                done_bl   = bytes_left;
                break;
            end
            word_valid = 1'b0;
            word_data  = '0;
            word_strb  = '0;
            if (wq_data.size() > 0) begin
                word_valid = ($urandom_range(99) < valid_pct);
                word_data  = wq_data[0];
                word_strb  = wq_strb[0];
            end
            tx_ready = ($urandom_range(99) < ready_pct);
            tr_bl.push_back(bytes_left);
            tr_cnt.push_back(got.size());
            tr_v.push_back(tx_valid);
            tr_d.push_back(tx_data);
            tr_r.push_back(tx_ready);
            tr_acc.push_back(word_valid && word_ready);
            if (tx_valid && tx_ready) got.push_back(tx_data);
            @(posedge clk);
            #1;
            if (tr_acc[$]) begin
                void'(wq_data.pop_front());
                void'(wq_strb.pop_front());
            end
        end
        word_valid = 1'b0;
        tx_ready   = 1'b0;
        @(posedge clk);
        #1;
        post_done = done;
        post_drop = drop;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (word_req !== 1'b0) begin errors++; $display("FAIL reset_word_req got %b exp 0", word_req); end
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready got %b exp 0", word_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        checks++; if (bytes_left !== '0) begin errors++; $display("FAIL reset_bytes_left got %0d exp 0", bytes_left); end
        checks++; if (done !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", done, drop); end
    endtask

    task automatic test_full_word();
        logic [8*StrbWidth-1:0] d;
        int                     act_acc[$];
        for (int i = 0; i < StrbWidth; i++) d[8*i +: 8] = 8'(i);
        clear_words();
        add_word(d, 16'hFFFF);
        model(16);
        run_xfer(16, 100, 100);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL full_timeout got %b exp 0", timed_out); end
        checks++; if (got.size() != exp_bytes.size()) begin errors++; $display("FAIL full_count got %0d exp %0d", got.size(), exp_bytes.size()); end
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
            checks++; if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL full_byte[%0d] got %h exp %h", i, got[i], exp_bytes[i]); end
        end
        for (int i = 0; i < tr_bl.size(); i++) begin
            checks++; if (tr_bl[i] !== LenWidth'(16 - tr_cnt[i])) begin errors++; $display("FAIL full_bytes_left[%0d] got %0d exp %0d", i + 1, tr_bl[i], 16 - tr_cnt[i]); end
        end
        for (int i = 0; i < tr_acc.size(); i++) if (tr_acc[i]) act_acc.push_back(i + 1);
        checks++; if (act_acc.size() != 1 || act_acc[0] != exp_acc[0]) begin errors++; $display("FAIL full_accepts got %0d words exp 1 at cycle %0d", act_acc.size(), exp_acc[0]); end
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL full_done_cycle got %0d exp %0d", done_cyc, exp_done); end
        checks++; if (done_bl !== '0) begin errors++; $display("FAIL full_final_left got %0d exp 0", done_bl); end
        checks++; if (saw_drop !== 1'b0) begin errors++; $display("FAIL full_drop got %b exp 0", saw_drop); end
        checks++; if (post_done !== 1'b0) begin errors++; $display("FAIL full_done_once got %b exp 0", post_done); end
    endtask

    task automatic test_two_words();
        int act_acc[$];
        clear_words();
        add_word({$urandom(), $urandom(), $urandom(), $urandom()}, 16'h00F0);
        add_word({$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0001);
        model(5);
        run_xfer(5, 100, 100);
        checks++; if (got.size() != 5) begin errors++; $display("FAIL two_count got %0d exp 5", got.size()); end
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
            checks++; if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL two_byte[%0d] got %h exp %h", i, got[i], exp_bytes[i]); end
        end
        for (int i = 0; i < tr_acc.size(); i++) if (tr_acc[i]) act_acc.push_back(i + 1);
        checks++; if (act_acc.size() != exp_acc.size()) begin errors++; $display("FAIL two_accept_count got %0d exp %0d", act_acc.size(), exp_acc.size()); end
        for (int i = 0; i < act_acc.size() && i < exp_acc.size(); i++) begin
            checks++; if (act_acc[i] != exp_acc[i]) begin errors++; $display("FAIL two_accept_cycle[%0d] got %0d exp %0d", i, act_acc[i], exp_acc[i]); end
        end
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL two_done_cycle got %0d exp %0d", done_cyc, exp_done); end
        checks++; if (saw_drop !== 1'b0) begin errors++; $display("FAIL two_drop got %b exp 0", saw_drop); end
    endtask

    task automatic test_drop();
        clear_words();
        add_word({$urandom(), $urandom(), $urandom(), $urandom()}, 16'h00FF);
        model(3);
        run_xfer(3, 100, 100);
        checks++; if (got.size() != 3) begin errors++; $display("FAIL drop_count got %0d exp 3", got.size()); end
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
            checks++; if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL drop_byte[%0d] got %h exp %h", i, got[i], exp_bytes[i]); end
        end
        checks++; if (saw_drop !== exp_drop) begin errors++; $display("FAIL drop_pulse got %b exp %b", saw_drop, exp_drop); end
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL drop_done_cycle got %0d exp %0d", done_cyc, exp_done); end
        checks++; if (done_req !== 1'b0) begin errors++; $display("FAIL drop_word_req got %b exp 0", done_req); end
        checks++; if (post_drop !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL drop_once got %b%b exp 00", post_drop, post_done); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop_tx_idle got %b exp 0", tx_valid); end
    endtask

    task automatic test_random_backpressure();
        int total;
        int en;
        logic [StrbWidth-1:0] s;
        for (int iter = 0; iter < 3; iter++) begin
            clear_words();
            total = 0;
            while (total < 40) begin
                s  = StrbWidth'($urandom_range(1, 16'hFFFF));
                en = $countones(s);
                total += en;
                add_word({$urandom(), $urandom(), $urandom(), $urandom()}, s);
            end
            model(40);
            run_xfer(40, 50, 70);
            checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %b exp 0", iter, timed_out); end
            checks++; if (got.size() != 40) begin errors++; $display("FAIL rand%0d_count got %0d exp 40", iter, got.size()); end
            for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
                checks++; if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL rand%0d_byte[%0d] got %h exp %h", iter, i, got[i], exp_bytes[i]); end
            end
            for (int i = 1; i < tr_v.size(); i++) begin
                if (tr_v[i-1] && !tr_r[i-1]) begin
                    checks++; if (tr_v[i] !== 1'b1 || tr_d[i] !== tr_d[i-1]) begin errors++; $display("FAIL rand%0d_stall[%0d] got %b/%h exp 1/%h", iter, i + 1, tr_v[i], tr_d[i], tr_d[i-1]); end
                end
            end
            for (int i = 0; i < tr_bl.size(); i++) begin
                checks++; if (tr_bl[i] !== LenWidth'(40 - tr_cnt[i])) begin errors++; $display("FAIL rand%0d_bytes_left[%0d] got %0d exp %0d", iter, i + 1, tr_bl[i], 40 - tr_cnt[i]); end
            end
            checks++; if (saw_drop !== exp_drop) begin errors++; $display("FAIL rand%0d_drop got %b exp %b", iter, saw_drop, exp_drop); end
            checks++; if (post_done !== 1'b0) begin errors++; $display("FAIL rand%0d_done_once got %b exp 0", iter, post_done); end
        end
    endtask

    task automatic test_zero_strobe();
        int act_acc[$];
        clear_words();
        add_word({$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0000);
        add_word({$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0003);
        model(2);
        run_xfer(2, 100, 100);
        for (int i = 0; i < tr_acc.size(); i++) if (tr_acc[i]) act_acc.push_back(i + 1);
        checks++; if (act_acc.size() != 2) begin errors++; $display("FAIL zstrb_accept_count got %0d exp 2", act_acc.size()); end
        for (int i = 0; i < act_acc.size() && i < exp_acc.size(); i++) begin
            checks++; if (act_acc[i] != exp_acc[i]) begin errors++; $display("FAIL zstrb_accept_cycle[%0d] got %0d exp %0d", i, act_acc[i], exp_acc[i]); end
        end
        checks++; if (tr_bl.size() < 3 || tr_bl[2] !== LenWidth'(2)) begin errors++; $display("FAIL zstrb_cnt_kept got %0d exp 2", (tr_bl.size() < 3) ? 0 : tr_bl[2]); end
        checks++; if (got.size() != 2 || got[0] !== exp_bytes[0] || got[1] !== exp_bytes[1]) begin errors++; $display("FAIL zstrb_bytes got %0d bytes exp %h %h", got.size(), exp_bytes[0], exp_bytes[1]); end
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL zstrb_done_cycle got %0d exp %0d", done_cyc, exp_done); end
    endtask

    task automatic test_zero_len();
        cfg_valid = 1'b1;
        cfg_len   = '0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zlen_done got %b exp 1", done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zlen_cfg_ready got %b exp 1", cfg_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (word_req !== 1'b0) begin errors++; $display("FAIL zlen_word_req[%0d] got %b exp 0", i, word_req); end
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL zlen_done_once[%0d] got %b exp 0", i, done); end
        end
    endtask

    task automatic test_abort();
        logic [8*StrbWidth-1:0] d;
        d         = {$urandom(), $urandom(), $urandom(), $urandom()};
        cfg_valid = 1'b1;
        cfg_len   = 8;
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
        word_valid = 1'b1;
        word_data  = d;
        word_strb  = 16'h00FF;
        tx_ready   = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bytes_left !== LenWidth'(6)) begin errors++; $display("FAIL abort_pre_left got %0d exp 6", bytes_left); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== d[23:16]) begin errors++; $display("FAIL abort_pre_byte got %b/%h exp 1/%h", tx_valid, tx_data, d[23:16]); end
        abort     = 1'b1;
        cfg_valid = 1'b1;
        cfg_len   = 4;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        tx_ready  = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid got %b exp 0", tx_valid); end
        checks++; if (bytes_left !== '0) begin errors++; $display("FAIL abort_bytes_left got %0d exp 0", bytes_left); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got %b exp 1", cfg_ready); end
        @(posedge clk);
        #1;
        checks++; if (word_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_cfg_ignored got %b%b exp 00", word_req, done); end
        clear_words();
        add_word({$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0F00);
        model(4);
        run_xfer(4, 100, 100);
        checks++; if (got.size() != 4) begin errors++; $display("FAIL abort_after_count got %0d exp 4", got.size()); end
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
            checks++; if (got[i] !== exp_bytes[i]) begin errors++; $display("FAIL abort_after_byte[%0d] got %h exp %h", i, got[i], exp_bytes[i]); end
        end
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL abort_after_done got %0d exp %0d", done_cyc, exp_done); end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1;
        cfg_len   = 8;
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
        word_valid = 1'b1;
        word_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        word_strb  = 16'hFFFF;
        tx_ready   = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        abort    = 1'b0;
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0 || bytes_left !== '0) begin errors++; $display("FAIL rstmid_state got %b/%0d exp 0/0", tx_valid, bytes_left); end
        checks++; if (cfg_ready !== 1'b1 || done !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_idle got %b/%b/%h exp 1/0/00", cfg_ready, done, tx_data); end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_len    = '0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        word_strb  = '0;
        tx_ready   = 1'b0;
        test_reset();
        test_full_word();
        test_two_words();
        test_drop();
        test_random_backpressure();
        test_zero_strobe();
        test_zero_len();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
